// File: rtl/vt52_input_arbiter.sv
// Two-source byte arbiter feeding the VT52 command handler: round-robin for plain
// characters, atomic ownership for ESC x / ESC Y row col, with a stall timeout.
module vt52_input_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_BITS        = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       owner,
  output logic       locked,
  output logic       seq_abort
);

  typedef enum logic [1:0] {IDLE, ESC1, YROW, YCOL} state_t;

  localparam logic [7:0]         ESC_BYTE = 8'h1B;
  localparam logic [7:0]         Y_BYTE   = 8'h59;
  localparam logic [TO_BITS-1:0] TO_LAST  = TO_BITS'(TIMEOUT_CYCLES - 1);

  state_t             state, state_nxt;
  logic               pref, pref_nxt;
  logic               lock_src, lock_src_nxt;
  logic [TO_BITS-1:0] cnt, cnt_nxt;
  logic               sel, xfer, timeout;

  // Reset forces source 0 so the handler never sees a stale grant from source 1.
  always_comb begin
    sel = 1'b0;
    if (reset)                     sel = 1'b0;
    else if (state != IDLE)        sel = lock_src;
    else if (s0_valid != s1_valid) sel = s1_valid;
    else                           sel = pref;
  end

  assign m_valid  = sel ? s1_valid : s0_valid;
  assign m_data   = sel ? s1_data  : s0_data;
  assign s0_ready = m_ready & ~sel;
  assign s1_ready = m_ready &  sel;
  assign owner    = sel;
  assign locked   = (state != IDLE);
  assign xfer     = m_valid & m_ready;
  // A transfer on the last allowed cycle still completes, so it suppresses the abort.
  assign timeout  = (state != IDLE) && !xfer && (cnt == TO_LAST);

  // NOTE: every output of this block gets a default first, so no latch is inferred
  // for the paths that leave a value unchanged.
  always_comb begin
    state_nxt    = state;
    pref_nxt     = pref;
    lock_src_nxt = lock_src;
    case (state)
      IDLE: if (xfer) begin
        if (m_data == ESC_BYTE) begin
          state_nxt    = ESC1;
          lock_src_nxt = sel;
        end else begin
          pref_nxt = ~sel;
        end
      end
      ESC1: if (xfer) begin
        if (m_data == Y_BYTE) begin
          state_nxt = YROW;
        end else begin
          state_nxt = IDLE;
          pref_nxt  = ~lock_src;
        end
      end
      YROW: if (xfer) state_nxt = YCOL;
      YCOL: if (xfer) begin
        state_nxt = IDLE;
        pref_nxt  = ~lock_src;
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) begin
      state_nxt = IDLE;
      pref_nxt  = ~lock_src;
    end
    cnt_nxt = (state == IDLE || xfer || timeout) ? '0 : cnt + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pref      <= 1'b0;
      lock_src  <= 1'b0;
      cnt       <= '0;
      seq_abort <= 1'b0;
    end else begin
      state     <= state_nxt;
      pref      <= pref_nxt;
      lock_src  <= lock_src_nxt;
      cnt       <= cnt_nxt;
      seq_abort <= timeout;
    end
  end

endmodule

// File: tb/tb_vt52_input_arbiter.sv
// Self-checking bench for vt52_input_arbiter: directed scenarios plus random traffic,
// all compared against a sequence-length model of the VT52 arbitration rules.
module tb_vt52_input_arbiter;

  localparam int T = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s0_data, s1_data, m_data;
  logic       s0_valid, s1_valid, m_ready;
  logic       s0_ready, s1_ready, m_valid, owner, locked, seq_abort;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who holds the lock, how many sequence bytes remain, and the stall length.
  bit mdl_pref, mdl_lock, mdl_src, mdl_cmd_phase, mdl_abort;
  int mdl_left, mdl_idle;

  vt52_input_arbiter #(.TIMEOUT_CYCLES(T), .TO_BITS(13)) dut (
    .clk(clk), .reset(reset),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .owner(owner), .locked(locked), .seq_abort(seq_abort)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic r);
    s0_valid = v0; s0_data = d0; s1_valid = v1; s1_data = d1; m_ready = r;
  endtask

  task automatic model_reset();
    mdl_pref = 0; mdl_lock = 0; mdl_src = 0; mdl_cmd_phase = 0;
    mdl_abort = 0; mdl_left = 0; mdl_idle = 0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_own"}, owner, 0);
    check({tag, "_lock"}, locked, 0);
    check({tag, "_rdy0"}, s0_ready, m_ready);
    check({tag, "_rdy1"}, s1_ready, 0);
    check({tag, "_abort"}, seq_abort, 0);
  endtask

  // Called just after a rising edge with inputs already driven; checks the cycle,
  // advances the model, and returns just after the next rising edge.
  task automatic step(input string tag, input int e_own = -1, input int e_dat = -1,
                      input int e_lock = -1, input int e_ab = -1);
    logic s, mv, x;
    logic [7:0] raw;
    logic [13:0] exp_v, got_v;
    @(negedge clk);
    s     = mdl_lock ? mdl_src : ((s0_valid ^ s1_valid) ? s1_valid : mdl_pref);
    mv    = s ? s1_valid : s0_valid;
    raw   = s ? s1_data : s0_data;
    exp_v = {s, mdl_lock, mv, m_ready & ~s, m_ready & s, mdl_abort, mv ? raw : 8'h00};
    got_v = {owner, locked, m_valid, s0_ready, s1_ready, seq_abort, m_valid ? m_data : 8'h00};
    check(tag, got_v, exp_v);
    if (e_own  >= 0) check({tag, "_own"}, owner, e_own);
    if (e_dat  >= 0) check({tag, "_dat"}, m_data, e_dat);
    if (e_lock >= 0) check({tag, "_lock"}, locked, e_lock);
    if (e_ab   >= 0) check({tag, "_abort"}, seq_abort, e_ab);
    x = mv && m_ready;
    mdl_abort = 0;
    if (x) begin
      mdl_idle = 0;
      if (!mdl_lock) begin
        if (raw == 8'h1B) begin
          mdl_lock = 1; mdl_src = s; mdl_cmd_phase = 1; mdl_left = 1;
        end else begin
          mdl_pref = ~s;
        end
      end else begin
        if (mdl_cmd_phase) begin
          mdl_cmd_phase = 0;
          mdl_left = (raw == 8'h59) ? 2 : 0;
        end else begin
          mdl_left--;
        end
        if (mdl_left == 0) begin
          mdl_lock = 0; mdl_pref = ~mdl_src;
        end
      end
    end else if (mdl_lock) begin
      mdl_idle++;
      if (mdl_idle == T) begin
        mdl_lock = 0; mdl_pref = ~mdl_src; mdl_abort = 1; mdl_idle = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 25) return 8'h1B;
    if (r < 45) return 8'h59;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [7:0] seq2 [4];
    logic       held;
    seq2 = '{8'h1B, 8'h59, 8'h25, 8'h30};

    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 8'h41, 1'b1);
    model_reset();
    #1;
    reset_checks("rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: plain characters alternate between the sources
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'h41, 1'b1, 8'h41, 1'b1);
      step("t1", i % 2, 8'h41, 0);
    end

    // 2: ESC Y row col from s0 is not interleaved with s1
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq2[i], 1'b1, 8'h42, 1'b1);
      step("t2", 0, seq2[i], (i == 0) ? 0 : 1);
    end
    drive(1'b0, 8'h00, 1'b1, 8'h42, 1'b1);
    step("t2_after", 1, 8'h42, 0);

    // 3: ESC H from s1, then s0 is served
    drive(1'b1, 8'h43, 1'b0, 8'h00, 1'b1);
    step("t3_pre", 0, 8'h43, 0);
    drive(1'b1, 8'h43, 1'b1, 8'h1B, 1'b1);
    step("t3_esc", 1, 8'h1B, 0);
    drive(1'b1, 8'h43, 1'b1, 8'h48, 1'b1);
    step("t3_cmd", 1, 8'h48, 1);
    drive(1'b1, 8'h43, 1'b1, 8'h41, 1'b1);
    step("t3_next", 0, 8'h43, 0);

    // 4: s0 stalls after ESC; lock is released after T idle cycles
    drive(1'b1, 8'h1B, 1'b0, 8'h00, 1'b1);
    step("t4_esc", 0, 8'h1B, 0);
    drive(1'b0, 8'h00, 1'b1, 8'h44, 1'b1);
    for (int i = 0; i < T; i++) step("t4_stall", 0, -1, 1, 0);
    step("t4_abort", 1, 8'h44, 0, 1);
    step("t4_post", -1, -1, -1, 0);

    // 4b: a transfer on the last allowed stall cycle wins over the timeout
    drive(1'b1, 8'h1B, 1'b0, 8'h00, 1'b1);
    step("t4b_esc", 0, 8'h1B, 0);
    drive(1'b0, 8'h00, 1'b1, 8'h44, 1'b1);
    for (int i = 0; i < T - 1; i++) step("t4b_stall", 0, -1, 1, 0);
    drive(1'b1, 8'h48, 1'b1, 8'h44, 1'b1);
    step("t4b_cmd", 0, 8'h48, 1, 0);
    drive(1'b0, 8'h00, 1'b1, 8'h44, 1'b1);
    step("t4b_post", 1, 8'h44, 0, 0);

    // 5: m_ready low freezes arbitration
    held = mdl_pref;
    drive(1'b1, 8'h45, 1'b1, 8'h46, 1'b0);
    for (int i = 0; i < 100; i++) step("t5", held, -1, 0, 0);
    drive(1'b1, 8'h45, 1'b1, 8'h46, 1'b1);
    step("t5_resume", held, -1, 0);

    // 6: reset in YCOL drops the partial sequence immediately
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, seq2[i], 1'b0, 8'h00, 1'b1);
      step("t6_seq", 0, seq2[i]);
    end
    drive(1'b0, 8'h00, 1'b1, 8'h47, 1'b1);
    check("t6_ycol_lock", locked, 1);
    reset = 1'b1;
    #1;
    model_reset();
    reset_checks("t6_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    step("t6_idle", 0, 8'h5A, 0);
    drive(1'b1, 8'h41, 1'b1, 8'h42, 1'b1);
    step("t6_rr", 1, 8'h42, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rand_byte(), $urandom_range(0, 3) != 0,
            rand_byte(), $urandom_range(0, 4) != 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
